// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and defaults for the fetch/data memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_IF   = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  localparam int unsigned N_DEFAULT       = 32;
  localparam int unsigned MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arb_rr2.sv
// rtl/mem_arb_rr2.sv - two-requester round-robin picker (fetch vs data)
module mem_arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic   req_if,
  input  logic   req_d,
  input  grant_e last_grant,
  output logic   grant_data,
  output logic   valid
);

  always_comb begin
    valid      = req_if | req_d;
    grant_data = req_d;
    // Under contention the port that did not win last time goes next.
    if (req_if && req_d) begin
      grant_data = (last_grant == GRANT_IF);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - sequences fetch and load/store requests onto the single main memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N       = 32,
  parameter int MEM_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [N-1:0] if_rdata,
  output logic         if_ready,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_ready,
  output logic [N-1:0] mem_adr,
  output logic [N-1:0] mem_din,
  input  logic [N-1:0] mem_dout,
  output logic         mem_write,
  output logic         mem_for_data,
  output logic         busy,
  output logic         grant_data
);

  localparam int CW        = $clog2(MEM_LAT) + 1;
  localparam int LAT_PRE_I = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
  localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] LAT_PRE  = CW'(LAT_PRE_I);

  arb_state_e    state_q;
  logic [CW-1:0] lat_cnt_q;
  grant_e        last_grant_q;
  logic          we_q;
  logic [N-1:0]  mem_adr_q;
  logic [N-1:0]  mem_din_q;
  logic          mem_write_q;
  logic          mem_for_data_q;
  logic [N-1:0]  if_rdata_q;
  logic [N-1:0]  d_rdata_q;
  logic          if_ready_q;
  logic          d_ready_q;

  logic pick_data_d;
  logic pick_valid_d;

  mem_arb_rr2 u_rr2 (
    .req_if     (if_req),
    .req_d      (d_req),
    .last_grant (last_grant_q),
    .grant_data (pick_data_d),
    .valid      (pick_valid_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      lat_cnt_q      <= '0;
      last_grant_q   <= GRANT_IF;
      we_q           <= 1'b0;
      mem_adr_q      <= '0;
      mem_din_q      <= '0;
      mem_write_q    <= 1'b0;
      mem_for_data_q <= 1'b0;
      if_rdata_q     <= '0;
      d_rdata_q      <= '0;
      if_ready_q     <= 1'b0;
      d_ready_q      <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid_d) begin
            last_grant_q   <= pick_data_d ? GRANT_DATA : GRANT_IF;
            mem_adr_q      <= pick_data_d ? d_addr : if_addr;
            mem_din_q      <= pick_data_d ? d_wdata : '0;
            we_q           <= pick_data_d & d_we;
            mem_for_data_q <= pick_data_d;
            lat_cnt_q      <= '0;
            // A single-cycle access has its only (and final) cycle right after the grant.
            mem_write_q    <= (MEM_LAT == 1) && pick_data_d && d_we;
            state_q        <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_cnt_q == LAT_LAST) begin
            mem_write_q <= 1'b0;
            if (!we_q) begin
              if (last_grant_q == GRANT_DATA) begin
                d_rdata_q <= mem_dout;
              end else begin
                if_rdata_q <= mem_dout;
              end
            end
            if (last_grant_q == GRANT_DATA) begin
              d_ready_q <= 1'b1;
            end else begin
              if_ready_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            lat_cnt_q   <= lat_cnt_q + CW'(1);
            // Raise the strobe entering the last access cycle so memory sees one rising edge.
            mem_write_q <= we_q && (lat_cnt_q == LAT_PRE);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign if_ready     = if_ready_q;
  assign d_ready      = d_ready_q;
  assign mem_adr      = mem_adr_q;
  assign mem_din      = mem_din_q;
  assign mem_write    = mem_write_q;
  assign mem_for_data = mem_for_data_q;
  assign busy         = (state_q != IDLE);
  assign grant_data   = (last_grant_q == GRANT_DATA);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a reference memory model
module tb_mem_arbiter;

  localparam int N    = 32;
  localparam int LAT  = 2;
  localparam int LAT4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          if_req, if_ready, d_req, d_we, d_ready;
  logic [N-1:0]  if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [N-1:0]  mem_adr, mem_din, mem_dout;
  logic          mem_write, mem_for_data, busy, grant_data;

  logic          if_req4, if_ready4, d_req4, d_we4, d_ready4;
  logic [N-1:0]  if_addr4, if_rdata4, d_addr4, d_wdata4, d_rdata4;
  logic [N-1:0]  mem_adr4, mem_din4, mem_dout4;
  logic          mem_write4, mem_for_data4, busy4, grant_data4;

  mem_arbiter #(.N(N), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_write(mem_write),
    .mem_for_data(mem_for_data), .busy(busy), .grant_data(grant_data)
  );

  mem_arbiter #(.N(N), .MEM_LAT(LAT4)) dut4 (
    .clk(clk), .rst(rst),
    .if_req(if_req4), .if_addr(if_addr4), .if_rdata(if_rdata4), .if_ready(if_ready4),
    .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4),
    .d_rdata(d_rdata4), .d_ready(d_ready4),
    .mem_adr(mem_adr4), .mem_din(mem_din4), .mem_dout(mem_dout4), .mem_write(mem_write4),
    .mem_for_data(mem_for_data4), .busy(busy4), .grant_data(grant_data4)
  );

  // Main memory models: word-indexed for data, byte address >> 2 for fetch.
  logic [31:0] mem0 [0:255];
  logic [31:0] mem4 [0:255];
  logic [7:0]  widx0, widx4;
  int          wr_edges  = 0;
  int          wr_edges4 = 0;
  assign widx0     = mem_for_data  ? mem_adr[7:0]  : mem_adr[9:2];
  assign widx4     = mem_for_data4 ? mem_adr4[7:0] : mem_adr4[9:2];
  assign mem_dout  = mem0[widx0];
  assign mem_dout4 = mem4[widx4];
  always @(posedge mem_write)  begin mem0[widx0] = mem_din;  wr_edges++;  end
  always @(posedge mem_write4) begin mem4[widx4] = mem_din4; wr_edges4++; end

  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_if, exp_d;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_if_ready"}, {31'd0, if_ready}, 0);
    check({tag, "_d_ready"}, {31'd0, d_ready}, 0);
    check({tag, "_mem_adr"}, mem_adr, 0);
    check({tag, "_mem_din"}, mem_din, 0);
    check({tag, "_mem_write"}, {31'd0, mem_write}, 0);
    check({tag, "_mem_for_data"}, {31'd0, mem_for_data}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_grant_data"}, {31'd0, grant_data}, 0);
  endtask

  // Follows one granted access from cycle 0 (arbiter idle, request raised) to the idle cycle after ready.
  task automatic track(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    int          wc0;
    logic [7:0]  w;
    logic [31:0] exp_rd;
    wc0    = wr_edges;
    w      = is_d ? addr[7:0] : addr[9:2];
    exp_rd = ref_mem[w];
    if (is_d && we) ref_mem[w] = wdata;
    for (int n = 0; n <= LAT + 1; n++) begin
      @(negedge clk);
      if (n >= 1 && n <= LAT) begin
        check("acc_busy", {31'd0, busy}, 1);
        check("acc_mem_adr", mem_adr, addr);
        check("acc_for_data", {31'd0, mem_for_data}, {31'd0, is_d});
        check("acc_grant_data", {31'd0, grant_data}, {31'd0, is_d});
        check("acc_mem_din", mem_din, is_d ? wdata : 32'd0);
        check("acc_mem_write", {31'd0, mem_write}, {31'd0, is_d && we && (n == LAT)});
      end
      check("if_ready_timing", {31'd0, if_ready}, {31'd0, !is_d && (n == LAT + 1)});
      check("d_ready_timing", {31'd0, d_ready}, {31'd0, is_d && (n == LAT + 1)});
      if (n == 1) begin
        if (is_d) begin d_addr = $urandom; d_wdata = $urandom; d_we = ~we; end
        else if_addr = $urandom;
      end
    end
    if (!(is_d && we)) begin
      if (is_d) exp_d = exp_rd;
      else exp_if = exp_rd;
    end
    check("if_rdata", if_rdata, exp_if);
    check("d_rdata", d_rdata, exp_d);
    check("write_edges", wr_edges - wc0, (is_d && we) ? 1 : 0);
    @(posedge clk);
    #1;
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    track(is_d, we, addr, wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, wd;
    bit          seq [0:7];
    bit          exp_first;
    int          nrdy, dcnt, icnt, rem_d, rem_i;
    bit          last_d, pick_d;
    int          wc0;

    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    if_req4 = 0; if_addr4 = 0; d_req4 = 0; d_we4 = 0; d_addr4 = 0; d_wdata4 = 0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem0[i] = v; ref_mem[i] = v;
      mem4[i] = $urandom;
    end
    mem0[3] = 32'h00A00593;  ref_mem[3] = 32'h00A00593;
    mem0[60] = 32'hFFFFFFFB; ref_mem[60] = 32'hFFFFFFFB;
    mem4[9] = 32'hCAFE0009;
    exp_if = 0; exp_d = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    access(0, 0, 32'h0000000C, 0);
    check("fetch_word3", if_rdata, 32'h00A00593);
    access(1, 0, 60, 0);
    check("load_word60", d_rdata, 32'hFFFFFFFB);
    access(1, 1, 70, 32'h00001234);
    check("store_keeps_d_rdata", d_rdata, 32'hFFFFFFFB);
    access(1, 0, 70, 0);
    check("load_after_store", d_rdata, 32'h00001234);

    // Contention from reset: both held until their second ready.
    #1 rst = 1'b1;
    exp_if = 0; exp_d = 0;
    if_req = 1; if_addr = 32'd20; d_req = 1; d_we = 0; d_addr = 32'd33;
    @(posedge clk);
    #1 rst = 1'b0;
    nrdy = 0; dcnt = 0; icnt = 0;
    for (int c = 0; c < 4 * (LAT + 2) + 6; c++) begin
      @(negedge clk);
      if (if_ready && d_ready) check("both_ready", 1, 0);
      if (d_ready || if_ready) begin
        if (nrdy < 8) seq[nrdy] = d_ready;
        nrdy++;
        if (d_ready) dcnt++; else icnt++;
      end
      @(posedge clk);
      #1;
      if (dcnt == 2) d_req = 0;
      if (icnt == 2) if_req = 0;
    end
    check("contention_ready_count", nrdy, 4);
    rem_d = 2; rem_i = 2; last_d = 0;
    for (int k = 0; k < 4 && k < nrdy; k++) begin
      if (rem_d > 0 && rem_i > 0) pick_d = !last_d;
      else pick_d = (rem_d > 0);
      if (pick_d) rem_d--; else rem_i--;
      last_d = pick_d;
      check($sformatf("grant_order_%0d", k), {31'd0, seq[k]}, {31'd0, pick_d});
    end
    exp_first = 1;
    check("first_grant_data", {31'd0, seq[0]}, {31'd0, exp_first});
    exp_if = ref_mem[5]; exp_d = ref_mem[33];
    check("contention_if_rdata", if_rdata, exp_if);
    check("contention_d_rdata", d_rdata, exp_d);

    // Reset in ACCESS cycle 1 of a store, then the held request re-executes.
    wd = $urandom;
    wc0 = wr_edges;
    d_req = 1; d_we = 1; d_addr = 32'd90; d_wdata = wd;
    @(negedge clk);
    @(negedge clk);
    check("midstore_busy", {31'd0, busy}, 1);
    #1 rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    @(negedge clk);
    check("midreset_no_write_edge", wr_edges - wc0, 0);
    check("midreset_no_ready", {31'd0, d_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_if = 0; exp_d = 0;
    track(1, 1, 32'd90, wd);
    access(1, 0, 90, 0);
    check("reexec_store_value", d_rdata, wd);

    for (int i = 0; i < 40; i++) begin
      bit          rd_is_d, rd_we;
      logic [31:0] rword;
      rd_is_d = 1'($urandom_range(0, 1));
      rd_we   = rd_is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      rword   = 32'($urandom_range(0, 255));
      access(rd_is_d, rd_we, rd_is_d ? rword : (rword << 2), $urandom);
    end

    // MEM_LAT=4 instance: single load.
    d_req4 = 1; d_we4 = 0; d_addr4 = 32'd9;
    for (int n = 0; n <= 7; n++) begin
      @(negedge clk);
      check($sformatf("lat4_busy_c%0d", n), {31'd0, busy4}, {31'd0, (n >= 1 && n <= 5)});
      check($sformatf("lat4_ready_c%0d", n), {31'd0, d_ready4}, {31'd0, n == 5});
      check("lat4_mem_write", {31'd0, mem_write4}, 0);
      if (n >= 1 && n <= 4) begin
        check("lat4_mem_adr", mem_adr4, 32'd9);
        check("lat4_for_data", {31'd0, mem_for_data4}, 1);
      end
      if (n == 5) begin
        check("lat4_d_rdata", d_rdata4, 32'hCAFE0009);
        @(posedge clk);
        #1 d_req4 = 0;
      end
    end
    check("lat4_no_writes", wr_edges4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequencer and arbiter that shares the single unified main memory between the multi-cycle core's instruction-fetch requester and its load/store requester. It accepts one request at a time and alternates grants fairly when both requesters contend. It drives the memory address, data, write strobe and address-mode select for a fixed access latency, then returns read data with a one-cycle ready pulse. It sits between the multi-cycle controller/datapath and main_mem.

Parameters:
N, 32, data and address width
MEM_LAT, 2, cycles the memory address/data are held per access (minimum 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
if_req  input  1  instruction fetch request; held until if_ready
if_addr  input  N  fetch byte address (PC)
if_rdata  output  N  fetched instruction word
if_ready  output  1  one-cycle pulse: if_rdata valid
d_req  input  1  data request; held until d_ready
d_we  input  1  1 = store, 0 = load; held with d_req
d_addr  input  N  data word index
d_wdata  input  N  store data
d_rdata  output  N  load data
d_ready  output  1  one-cycle pulse: access complete, d_rdata valid for loads
mem_adr  output  N  address to main memory
mem_din  output  N  write data to main memory
mem_dout  input  N  read data from main memory
mem_write  output  1  memory write strobe (memory writes on its rising edge)
mem_for_data  output  1  1 = word-index addressing (data), 0 = byte addressing (memory shifts right by 2)
busy  output  1  1 while not IDLE
grant_data  output  1  1 when the current/last grant is the data port

Behaviour:
- Reset, asynchronous: state=IDLE, lat_cnt=0, last_grant=instruction. All outputs 0: if_rdata, d_rdata, ready pulses, mem_adr, mem_din, mem_write, mem_for_data, busy, grant_data.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples requests each edge.
  - Only one req high: grant it.
  - Both high: grant the port opposite to last_grant. After reset, data wins first.
  - On grant: latch addr, we and wdata; set grant_data and last_grant; lat_cnt=0; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS, lasting exactly MEM_LAT cycles:
  - mem_adr = latched address; mem_for_data = grant_data; mem_din = latched wdata for data grants, else 0.
  - mem_write=1 only in the final ACCESS cycle, and only for a data store: a single rising edge per store.
  - At the final ACCESS edge: on a read, capture mem_dout into if_rdata or d_rdata; go to RESP.
- RESP, one cycle:
  - The granted port's ready=1.
  - mem_write=0; mem_adr and mem_for_data held.
  - Next state IDLE.
- Latency: req high in cycle 0 (arbiter IDLE) gives ready in cycle MEM_LAT+1 (cycle 3 at default). Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Rdata registers update only on completed reads of their own port; stores leave d_rdata unchanged. Values hold until the next such read.
- Handshake:
  - Requester holds req, addr, we and wdata stable until ready.
  - A req still high in the cycle after ready is treated as a new request.
  - Changing inputs after grant has no effect; latched copies are used.
  - A req that drops before grant is ignored.
- busy = (state != IDLE).
- Simultaneous events: a request arriving during ACCESS/RESP waits; it is arbitrated in IDLE.
- Reset mid-operation: the access is aborted immediately and no ready is issued. mem_write falls to 0 without creating a rising edge. A store whose strobe already rose has completed in memory.
- lat_cnt width: clog2(MEM_LAT)+1. It never wraps within an access.

Decomposition:
- Shared package: FSM state encodings (IDLE/ACCESS/RESP), grant encoding (GRANT_IF=0, GRANT_DATA=1), default MEM_LAT.
- One sub-module, mem_arb_rr2: two-requester round-robin picker. Inputs: req_if, req_d, last_grant. Output: grant_data, valid.
- FSM, latency counter and output registers remain in mem_arbiter.

Test Plan:
- Fetch: if_req=1, if_addr=32'h0000000C, memory word 3 = 32'h00A00593 -> mem_adr=12, mem_for_data=0 during ACCESS; if_ready pulse in cycle 3; if_rdata=32'h00A00593; mem_write never high.
- Load: d_req=1, d_we=0, d_addr=60, memory word 60 = -5 -> mem_for_data=1, mem_adr=60; d_ready in cycle 3; d_rdata=32'hFFFFFFFB.
- Store then load: store d_addr=70, d_wdata=32'h00001234 -> exactly one mem_write rising edge, in ACCESS cycle 2, and d_rdata unchanged. Following load of word 70 returns 32'h00001234.
- Contention: if_req and d_req both high from reset, each held across its ready and deasserted after its second ready -> grant order data, if, data, if; no port granted twice in a row; each ready a single pulse.
- Reset mid-store: rst asserted in ACCESS cycle 1 of a store -> mem_write never rises, d_ready never pulses, all outputs 0. After rst release with d_req still high, the store re-executes fully.
- MEM_LAT=4 instance: single load -> ACCESS lasts 4 cycles, d_ready in cycle 5; busy high in cycles 1-5.
